branch_cond_unit: RTL and testbench

- Consumes ALU result and flag signals, the inverse end of the zero-flag path.
- Holds the architectural NZCV flag register and accepts branch requests over a valid/ready handshake.
- Resolves B, B.cond, CBZ and CBNZ, and returns a registered taken/not-taken result.
- Stalls B.cond while a flag-setting instruction is still in flight, with a watchdog on the stall.
- Sits between the ALU/execute stage and the PC-update logic of the CPU datapath.

---
 rtl/branch_cond_unit.sv | 149 ++++++++++++++
 tb/tb_branch_cond_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// Branch resolution unit: holds NZCV, resolves B/B.cond/CBZ/CBNZ over a valid/ready
// handshake, and stalls B.cond on in-flight flag writers with a bounded watchdog.
module branch_cond_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STALL_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    input  logic             set_flags,
    input  logic             flag_pending,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_type,
    input  logic [3:0]       br_cond,
    input  logic [WIDTH-1:0] br_operand,
    output logic             br_done,
    output logic             br_taken,
    output logic             br_err,
    output logic [3:0]       flags_q
);

    localparam int unsigned CW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [3:0]      cond_q;
    logic [1:0]      type_q;
    logic            op_zero_q;
    logic [3:0]      new_flags, eff_flags;
    logic            op_zero, cnt_last;
    logic            accept, stall, resolve, abort, resolve_taken;

    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    cond_met = z;
            4'h1:    cond_met = !z;
            4'h2:    cond_met = c;
            4'h3:    cond_met = !c;
            4'h4:    cond_met = n;
            4'h5:    cond_met = !n;
            4'h6:    cond_met = v;
            4'h7:    cond_met = !v;
            4'h8:    cond_met = c & !z;
            4'h9:    cond_met = !c | z;
            4'hA:    cond_met = (n == v);
            4'hB:    cond_met = (n != v);
            4'hC:    cond_met = !z & (n == v);
            4'hD:    cond_met = z | (n != v);
            default: cond_met = 1'b1;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [1:0] t, input logic [3:0] cond,
                                          input logic [3:0] f, input logic opz);
        case (t)
            2'b00:   branch_taken = 1'b1;
            2'b01:   branch_taken = cond_met(cond, f);
            2'b10:   branch_taken = opz;
            default: branch_taken = !opz;
        endcase
    endfunction

    // Forwarding: a flag write in this cycle is visible to the branch resolved in it.
    assign new_flags = {alu_result[WIDTH-1], ~|alu_result, alu_carry, alu_ovf};
    assign eff_flags = set_flags ? new_flags : flags_q;
    assign op_zero   = (br_operand == '0);
    assign cnt_last  = (cnt == CW'(STALL_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        stall         = 1'b0;
        resolve       = 1'b0;
        abort         = 1'b0;
        resolve_taken = 1'b0;
        case (state)
            IDLE: begin
                resolve_taken = branch_taken(br_type, br_cond, eff_flags, op_zero);
                if (br_valid) begin
                    accept = 1'b1;
                    if (br_type == 2'b01 && flag_pending && !set_flags) begin
                        stall      = 1'b1;
                        state_next = WAIT;
                    end else begin
                        resolve    = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                resolve_taken = branch_taken(type_q, cond_q, eff_flags, op_zero_q);
                if (set_flags) begin
                    resolve    = 1'b1;
                    state_next = RESP;
                end else if (cnt_last) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        br_ready = (state == IDLE);
        br_done  = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= '0;
            cnt       <= '0;
            cond_q    <= '0;
            type_q    <= '0;
            op_zero_q <= 1'b0;
            br_taken  <= 1'b0;
            br_err    <= 1'b0;
        end else begin
            if (set_flags) flags_q <= new_flags;
            if (accept) begin
                cond_q    <= br_cond;
                type_q    <= br_type;
                op_zero_q <= op_zero;
            end
            if (stall)              cnt <= '0;
            else if (state == WAIT) cnt <= cnt + CW'(1);
            if (resolve) begin
                br_taken <= resolve_taken;
                br_err   <= 1'b0;
            end else if (abort) begin
                br_taken <= 1'b0;
                br_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed steps plus randomized requests checked
// against an ARM-pseudocode style condition model.
module tb_branch_cond_unit;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned STALL_MAX = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry, alu_ovf, set_flags, flag_pending;
    logic             br_valid, br_ready;
    logic [1:0]       br_type;
    logic [3:0]       br_cond;
    logic [WIDTH-1:0] br_operand;
    logic             br_done, br_taken, br_err;
    logic [3:0]       flags_q;

    int total = 0;
    int bad   = 0;
    logic [3:0] model_flags;

    branch_cond_unit #(.WIDTH(WIDTH), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .reset(reset), .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_ovf(alu_ovf), .set_flags(set_flags), .flag_pending(flag_pending),
        .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type), .br_cond(br_cond),
        .br_operand(br_operand), .br_done(br_done), .br_taken(br_taken), .br_err(br_err),
        .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // NZCV as the architecture defines it: sign, zero, carry, overflow.
    function automatic logic [3:0] model_nzcv(input logic [31:0] res, input logic cy, input logic ov);
        logic n, z;
        n = ($signed(res) < 0);
        z = (res == 32'd0);
        return {n, z, cy, ov};
    endfunction

    // ARM ConditionHolds(): base test on cond[3:1], inverted by cond[0] except for 1111.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    function automatic logic model_taken(input logic [1:0] t, input logic [3:0] c, input logic [31:0] op);
        case (t)
            2'd0:    return 1'b1;
            2'd1:    return model_cond(c, model_flags);
            2'd2:    return op == 32'd0;
            default: return op != 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        br_valid = 1'b0; set_flags = 1'b0; flag_pending = 1'b0;
    endtask

    // Non-stalling request; response must appear one cycle after acceptance.
    task automatic issue(input string tag, input logic [1:0] t, input logic [3:0] c,
                         input logic [31:0] op, input logic sf, input logic [31:0] res,
                         input logic cy, input logic ov, input logic pend);
        logic exp;
        br_valid = 1'b1; br_type = t; br_cond = c; br_operand = op;
        set_flags = sf; alu_result = res; alu_carry = cy; alu_ovf = ov; flag_pending = pend;
        if (sf) model_flags = model_nzcv(res, cy, ov);
        exp = model_taken(t, c, op);
        tick();
        idle_inputs();
        br_operand = ~op;
        check({tag, "_done"}, 32'(br_done), 32'd1);
        check({tag, "_taken"}, 32'(br_taken), 32'(exp));
        check({tag, "_err"}, 32'(br_err), 32'd0);
        check({tag, "_flags"}, 32'(flags_q), 32'(model_flags));
        check({tag, "_busy"}, 32'(br_ready), 32'd0);
        tick();
        check({tag, "_ready"}, 32'(br_ready), 32'd1);
        check({tag, "_hold"}, 32'(br_taken), 32'(exp));
    endtask

    initial begin
        int k;
        logic [1:0]  rt;
        logic [3:0]  rc;
        logic [31:0] rop, rres;
        logic        rsf, rcy, rov, rpend, exp;

        reset = 1'b1; alu_result = '0; alu_carry = 1'b0; alu_ovf = 1'b0;
        br_type = '0; br_cond = '0; br_operand = '0;
        idle_inputs();
        model_flags = 4'b0000;
        tick(); tick();
        check("rst_flags", 32'(flags_q), 32'd0);
        check("rst_ready", 32'(br_ready), 32'd1);
        check("rst_done", 32'(br_done), 32'd0);
        check("rst_taken", 32'(br_taken), 32'd0);
        check("rst_err", 32'(br_err), 32'd0);
        reset = 1'b0;

        set_flags = 1'b1; alu_result = 32'd0; alu_carry = 1'b1; alu_ovf = 1'b0;
        tick();
        set_flags = 1'b0; alu_result = 32'h1234;
        check("flag_write", 32'(flags_q), 32'b0110);
        tick();
        check("flag_hold", 32'(flags_q), 32'b0110);

        reset = 1'b1; tick(); reset = 1'b0;
        model_flags = 4'b0000;
        check("rst2_flags", 32'(flags_q), 32'd0);
        issue("fwd_lt", 2'd1, 4'hB, 32'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);

        issue("cbz_zero", 2'd2, 4'h0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        issue("cbz_nz", 2'd2, 4'h0, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        issue("cbnz_nz", 2'd3, 4'h0, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        issue("b_pend", 2'd0, 4'h0, 32'h5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

        // Stall, then resolve on a flag write.
        flag_pending = 1'b1; br_valid = 1'b1; br_type = 2'd1; br_cond = 4'h0;
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 32'(br_ready), 32'd0);
            check("stall_done", 32'(br_done), 32'd0);
            if (i < 2) tick();
        end
        set_flags = 1'b1; alu_result = 32'd0; alu_carry = 1'b0; alu_ovf = 1'b0; flag_pending = 1'b0;
        model_flags = model_nzcv(32'd0, 1'b0, 1'b0);
        tick();
        set_flags = 1'b0;
        check("stall_resp_done", 32'(br_done), 32'd1);
        check("stall_resp_taken", 32'(br_taken), 32'd1);
        check("stall_resp_err", 32'(br_err), 32'd0);
        tick();

        // Watchdog expiry: GE would be true on current flags, abort forces not-taken.
        check("wd_ge_true", 32'(model_cond(4'hA, flags_q)), 32'd1);
        flag_pending = 1'b1; br_valid = 1'b1; br_type = 2'd1; br_cond = 4'hA;
        tick();
        br_valid = 1'b0;
        k = 1;
        while (br_done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("wd_latency", 32'(k), 32'(STALL_MAX + 1));
        check("wd_err", 32'(br_err), 32'd1);
        check("wd_taken", 32'(br_taken), 32'd0);
        flag_pending = 1'b0;
        tick();

        // Flag write on the last allowed stall cycle resolves normally.
        flag_pending = 1'b1; br_valid = 1'b1; br_type = 2'd1; br_cond = 4'h4;
        tick();
        br_valid = 1'b0;
        repeat (STALL_MAX - 1) tick();
        check("edge_no_done", 32'(br_done), 32'd0);
        set_flags = 1'b1; alu_result = 32'hF000_0001; alu_carry = 1'b0; alu_ovf = 1'b1;
        model_flags = model_nzcv(32'hF000_0001, 1'b0, 1'b1);
        tick();
        idle_inputs();
        check("edge_done", 32'(br_done), 32'd1);
        check("edge_err", 32'(br_err), 32'd0);
        check("edge_taken", 32'(br_taken), 32'd1);
        tick();

        for (int i = 0; i < 60; i++) begin
            rt    = 2'($urandom_range(0, 3));
            rc    = 4'($urandom_range(0, 15));
            rop   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rsf   = 1'($urandom_range(0, 1));
            rres  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rcy   = 1'($urandom_range(0, 1));
            rov   = 1'($urandom_range(0, 1));
            rpend = 1'($urandom_range(0, 1));
            if (rt == 2'd1 && rpend && !rsf) begin
                flag_pending = 1'b1; br_valid = 1'b1; br_type = rt; br_cond = rc; br_operand = rop;
                tick();
                br_valid = 1'b0;
                repeat ($urandom_range(0, STALL_MAX - 1)) tick();
                check("rnd_stall_ready", 32'(br_ready), 32'd0);
                set_flags = 1'b1; alu_result = rres; alu_carry = rcy; alu_ovf = rov;
                model_flags = model_nzcv(rres, rcy, rov);
                exp = model_cond(rc, model_flags);
                tick();
                idle_inputs();
                check("rnd_stall_done", 32'(br_done), 32'd1);
                check("rnd_stall_taken", 32'(br_taken), 32'(exp));
                check("rnd_stall_err", 32'(br_err), 32'd0);
                check("rnd_stall_flags", 32'(flags_q), 32'(model_flags));
                tick();
            end else begin
                issue("rnd", rt, rc, rop, rsf, rres, rcy, rov, rpend);
            end
        end

        // Reset in WAIT abandons the request and clears the flags.
        set_flags = 1'b1; alu_result = 32'h8000_0000; alu_carry = 1'b1; alu_ovf = 1'b0;
        tick();
        set_flags = 1'b0;
        check("pre_rst_flags", 32'(flags_q), 32'b1010);
        flag_pending = 1'b1; br_valid = 1'b1; br_type = 2'd1; br_cond = 4'h0;
        tick();
        br_valid = 1'b0;
        tick();
        check("wait_before_rst", 32'(br_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0; flag_pending = 1'b0;
        check("rst_wait_ready", 32'(br_ready), 32'd1);
        check("rst_wait_done", 32'(br_done), 32'd0);
        check("rst_wait_flags", 32'(flags_q), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_wait_no_pulse", 32'(br_done), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
